// File: rtl/lzw_frame_seq.sv
// Frame sequencer for the LZW datapath: captures a received frame, runs code-RAM init and the
// encoder, then transmits a 2-byte code count followed by the codes bit-packed LSB-first.
module lzw_frame_seq #(
  parameter int ADDR_W   = 12,
  parameter int CODE_W   = 12,
  parameter int IDLE_CYC = 33000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rcv_done,
  input  logic [7:0]        rcv_byte,
  output logic              ioram_we,
  output logic [ADDR_W-1:0] ioram_addr,
  output logic              init_cr,
  input  logic              done_cr,
  output logic              init_lzw,
  output logic [ADDR_W:0]   char_cnt,
  input  logic              lzw_done,
  input  logic [ADDR_W:0]   code_cnt,
  output logic              out_en,
  output logic [ADDR_W-1:0] out_addr,
  input  logic [CODE_W-1:0] out_code,
  output logic              start_xmt,
  output logic [7:0]        xmt_byte,
  input  logic              xmt_done,
  output logic              busy,
  output logic              final_done,
  output logic              drop_err
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int ACC_W  = CODE_W + 7;
  localparam int NB_W   = $clog2(CODE_W + 8);
  localparam int IDLE_W = $clog2(IDLE_CYC);

  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'((1 << ADDR_W) - 1);
  localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(IDLE_CYC - 2);
  localparam logic [NB_W-1:0]   NB_BYTE  = NB_W'(8);
  localparam logic [NB_W-1:0]   NB_CODE  = NB_W'(CODE_W);

  typedef enum logic [3:0] {
    S_IDLE, S_RECV, S_INIT_CR, S_WAIT_CR, S_RUN_LZW, S_WAIT_LZW, S_HDR_LO,
    S_HDR_LO_W, S_HDR_HI, S_XWAIT, S_PACK, S_FETCH, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  ncodes;
  logic [CNT_W-1:0]  idx;
  logic [IDLE_W-1:0] idle_cnt;
  logic [ACC_W-1:0]  acc;
  logic [NB_W-1:0]   nb;
  logic [15:0]       hdr;
  logic              rx_ok;
  logic              xmt_go;
  logic [7:0]        xmt_dat;

  assign hdr        = 16'(ncodes);
  assign rx_ok      = (state == S_IDLE) || (state == S_RECV) || (state == S_DONE);
  assign ioram_we   = rcv_done && rx_ok;
  assign ioram_addr = (state == S_RECV) ? cnt[ADDR_W-1:0] : '0;
  assign init_cr    = (state == S_INIT_CR);
  assign init_lzw   = (state == S_RUN_LZW);
  assign char_cnt   = cnt;
  assign out_addr   = idx[ADDR_W-1:0];
  assign busy       = !((state == S_IDLE) || (state == S_DONE));
  assign final_done = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    xmt_go    = 1'b0;
    xmt_dat   = acc[7:0];
    out_en    = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (rcv_done) state_nxt = S_RECV;
      S_RECV: begin
        if (rcv_done) begin
          if (cnt == LAST_IDX) state_nxt = S_INIT_CR;
        end else if (idle_cnt == IDLE_END) begin
          state_nxt = S_INIT_CR;
        end
      end
      S_INIT_CR:  state_nxt = S_WAIT_CR;
      S_WAIT_CR:  if (done_cr) state_nxt = S_RUN_LZW;
      S_RUN_LZW:  state_nxt = S_WAIT_LZW;
      S_WAIT_LZW: if (lzw_done) state_nxt = S_HDR_LO;
      S_HDR_LO: begin
        xmt_go    = 1'b1;
        xmt_dat   = hdr[7:0];
        state_nxt = S_HDR_LO_W;
      end
      S_HDR_LO_W: if (xmt_done) state_nxt = S_HDR_HI;
      S_HDR_HI: begin
        xmt_go    = 1'b1;
        xmt_dat   = hdr[15:8];
        state_nxt = S_XWAIT;
      end
      S_XWAIT: if (xmt_done) state_nxt = S_PACK;
      S_PACK: begin
        // Drain whole bytes first so the accumulator never holds more than CODE_W+7 bits.
        if (nb >= NB_BYTE) begin
          xmt_go    = 1'b1;
          state_nxt = S_XWAIT;
        end else if (idx < ncodes) begin
          out_en    = 1'b1;
          state_nxt = S_FETCH;
        end else if (nb != '0) begin
          xmt_go    = 1'b1;
          state_nxt = S_XWAIT;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_FETCH: state_nxt = S_PACK;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ncodes    <= '0;
      idx       <= '0;
      idle_cnt  <= '0;
      acc       <= '0;
      nb        <= '0;
      start_xmt <= 1'b0;
      xmt_byte  <= '0;
      drop_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      start_xmt <= xmt_go;
      if (xmt_go) xmt_byte <= xmt_dat;
      case (state)
        S_IDLE, S_DONE: begin
          if (rcv_done) begin
            cnt      <= CNT_W'(1);
            idle_cnt <= '0;
            drop_err <= 1'b0;
          end
        end
        S_RECV: begin
          if (rcv_done) begin
            cnt      <= cnt + CNT_W'(1);
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        S_WAIT_LZW: begin
          if (lzw_done) begin
            ncodes <= code_cnt;
            idx    <= '0;
            nb     <= '0;
            acc    <= '0;
          end
        end
        S_PACK: begin
          if (nb >= NB_BYTE) begin
            acc <= acc >> 8;
            nb  <= nb - NB_BYTE;
          end else if (!(idx < ncodes) && (nb != '0)) begin
            acc <= '0;
            nb  <= '0;
          end
        end
        S_FETCH: begin
          acc <= acc | (ACC_W'(out_code) << nb);
          nb  <= nb + NB_CODE;
          idx <= idx + CNT_W'(1);
        end
        default: ;
      endcase
      if (rcv_done && !rx_ok) drop_err <= 1'b1;
    end
  end

endmodule

// File: doc/lzw_frame_seq.md
Name: lzw_frame_seq

Overview:
Parametrised top-level sequencer for the LZW datapath. It owns one complete frame transaction:
- captures serial receive bytes into the IO RAM and detects end of frame;
- sequences code-RAM initialisation and the LZW encoder;
- streams the resulting CODE_W-bit codes back to the serial transmitter, bit-packed into bytes behind a 2-byte code-count header.

Compared with the fixed 8-bit, fixed-count flow it replaces, it adds idle-timeout framing, overflow dropping, variable code width packing and back-to-back frames.

Parameters:
ADDR_W, 12, IO/out RAM address width; legal range 4..15.
CODE_W, 12, LZW code width in bits; legal range 9..16.
IDLE_CYC, 33000, idle clk cycles after the last received byte that close a frame; must be >= 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rcv_done  in  1  one-cycle pulse: rcv_byte is valid
rcv_byte  in  8  received byte; the IO RAM write data is wired directly from this
ioram_we  out  1  IO RAM port A write strobe
ioram_addr  out  ADDR_W  IO RAM port A address
init_cr  out  1  one-cycle pulse: initialise code RAM
done_cr  in  1  code RAM initialisation complete (pulse or level)
init_lzw  out  1  one-cycle pulse: start encoder
char_cnt  out  ADDR_W+1  byte count of the frame, held stable from init_lzw until the next frame
lzw_done  in  1  encoder finished; code_cnt is valid in the same cycle
code_cnt  in  ADDR_W+1  number of codes written to the out RAM
out_en  out  1  out RAM read enable
out_addr  out  ADDR_W  out RAM read address
out_code  in  CODE_W  out RAM read data, valid 1 cycle after out_en
start_xmt  out  1  one-cycle pulse: transmit xmt_byte
xmt_byte  out  8  byte to transmit, held until xmt_done
xmt_done  in  1  one-cycle pulse: transmitter finished the byte
busy  out  1  high in every state except IDLE and DONE
final_done  out  1  frame fully transmitted; high in DONE
drop_err  out  1  sticky: a byte arrived while not in IDLE, RECV or DONE

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and every counter and the accumulator are cleared. Reset asserted mid-frame aborts immediately; there is no partial output.
- IDLE / DONE:
  - rcv_done writes the byte at address 0 (ioram_we=1, ioram_addr=0 in the same cycle).
  - cnt becomes 1, drop_err and final_done clear, and the state goes to RECV.
- RECV:
  - Each rcv_done writes at address cnt, increments cnt and clears the idle counter.
  - With no rcv_done, the idle counter increments. On reaching IDLE_CYC-1, the state goes to INIT_CR.
  - rcv_done in the same cycle as idle expiry: the byte is written and the timer restarts.
  - When cnt reaches 2^ADDR_W after a write, the state goes to INIT_CR immediately.
- INIT_CR: pulse init_cr for 1 cycle, then go to WAIT_CR.
- WAIT_CR: wait for done_cr, then go to RUN_LZW.
- RUN_LZW: pulse init_lzw for 1 cycle with char_cnt=cnt, then go to WAIT_LZW.
- WAIT_LZW: on lzw_done, latch code_cnt into ncodes and go to TX_HDR.
- TX_HDR: send ncodes[7:0], then ncodes[15:8] (zero-extended), each as one start_xmt pulse followed by a wait for xmt_done.
- Packing loop:
  - Bit accumulator is CODE_W+7 bits wide, with bit counter nb.
  - If nb>=8: send acc[7:0], shift acc right by 8, subtract 8 from nb.
  - Else if codes remain: assert out_en with out_addr = code index. One cycle later, OR out_code<<nb into acc, add CODE_W to nb, and increment the index.
  - Else if nb>0: send acc[7:0] zero-padded, then set nb=0.
  - Else: go to DONE.
  - Codes are packed LSB-first. Payload bytes = ceil(ncodes*CODE_W/8).
  - ncodes=0: header only, then DONE.
- start_xmt is a 1-cycle pulse. The next start_xmt is never issued before the xmt_done for the previous byte. xmt_done outside a wait state is ignored.
- drop_err: a rcv_done in any of INIT_CR..TX states is discarded (no RAM write) and sets drop_err.
- DONE holds final_done=1 until the next frame's first byte.

Test Plan:
- 5 bytes 0x41 0x42 0x41 0x42 0x41, then idle -> writes at addresses 0..4; init_cr exactly IDLE_CYC cycles after the last rcv_done; char_cnt=5 at init_lzw.
- CODE_W=12, code_cnt=3, codes 0x041 0x042 0x100 -> xmt_byte sequence 0x03 0x00 0x41 0x20 0x04 0x00 0x01; then final_done=1, busy=0.
- ADDR_W=4, 20 back-to-back bytes -> 16 writes (addresses 0..15); INIT_CR is entered after byte 16 with no timeout wait; char_cnt=16; bytes 17..20 dropped and drop_err=1.
- CODE_W=9, code_cnt=0 -> header 0x00 0x00 only; no out_en; DONE.
- Transmitter stalls 1000 cycles per byte -> exactly one start_xmt per xmt_done; xmt_byte stable while waiting; a spurious xmt_done in WAIT_LZW has no effect.
- Reset asserted during TX payload, then a new 1-byte frame -> all outputs 0 during reset; the new frame is written at address 0 and runs to completion.
